// File: rtl/pwm_controller.sv
// pwm_controller: sixteen-channel PWM/static output stage fed by the SPI
// configuration registers. A prescaler divides clk by CLK_DIV into counter
// ticks; an 8-bit period counter produces a 256-tick PWM period. Each channel
// registers either a static high, the shared PWM level, or a forced low.
//
// Build option: define PWM_SHADOW_EN to latch the duty value once per period
// (glitch-free period updates). Without it the live duty input drives the
// comparator directly.
//
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   en_reg_out_7_0/15_8 per-channel output enable
//   en_reg_pwm_7_0/15_8 per-channel PWM mode select
//   pwm_duty_cycle      shared duty value (0x00 = never high, 0xFF = always high)
//   pwm_out             registered channel levels, bit i = channel i
//   period_start        one-cycle pulse following each period wrap
module pwm_controller #(
    parameter int unsigned CLK_DIV = 3000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] pwm_out,
    output logic        period_start
);

    localparam int unsigned DIV_W = 16;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned CH_N  = 16;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};

    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] pwm_cnt;
    logic [CNT_W-1:0] duty_c;
    logic             tick_c;
    logic             boundary_c;
    logic             pwm_lvl_c;
    logic [CH_N-1:0]  en_out_c;
    logic [CH_N-1:0]  en_pwm_c;

    assign en_out_c   = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm_c   = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign tick_c     = (div_cnt == DIV_LAST);
    assign boundary_c = tick_c && (pwm_cnt == CNT_LAST);

    // Prescaler and period counter; pwm_cnt wraps naturally at 0xFF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            pwm_cnt <= '0;
        end else begin
            div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);
            if (tick_c) begin
                pwm_cnt <= pwm_cnt + CNT_W'(1);
            end
        end
    end

`ifdef PWM_SHADOW_EN
    logic [CNT_W-1:0] duty_sh;

    // Duty shadow: only updated on the period boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_sh <= '0;
        end else if (boundary_c) begin
            duty_sh <= pwm_duty_cycle;
        end
    end

    assign duty_c = duty_sh;
`else
    assign duty_c = pwm_duty_cycle;
`endif

    // 0xFF is special-cased so full duty has no low count at 0xFF.
    assign pwm_lvl_c = (duty_c == CNT_LAST) || (pwm_cnt < duty_c);

    // Registered channel select and period marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out      <= '0;
            period_start <= 1'b0;
        end else begin
            pwm_out      <= en_out_c & (~en_pwm_c | {CH_N{pwm_lvl_c}});
            period_start <= boundary_c;
        end
    end

endmodule

// File: tb/tb_pwm_controller.sv
module tb_pwm_controller;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned PERIOD  = 256 * CLK_DIV;
    localparam int unsigned WAIT_MAX = PERIOD + 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] en_out = '0;
    logic [15:0] en_pwm = '0;
    logic [7:0]  duty = '0;
    logic [15:0] pwm_out;
    logic        period_start;

    pwm_controller #(.CLK_DIV(CLK_DIV)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_out[7:0]),
        .en_reg_out_15_8 (en_out[15:8]),
        .en_reg_pwm_7_0  (en_pwm[7:0]),
        .en_reg_pwm_15_8 (en_pwm[15:8]),
        .pwm_duty_cycle  (duty),
        .pwm_out         (pwm_out),
        .period_start    (period_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] out;
        logic        ps;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    logic have_exp;
    int   tests = 0;
    int   fails = 0;

    // Reference model: pushes the expected post-edge outputs at every edge.
    logic [15:0] m_div;
    logic [7:0]  m_cnt;
    logic [7:0]  m_duty;
    logic [7:0]  m_dsel;
    logic        m_tick;
    logic        m_bnd;
    logic        m_lvl;
    logic [15:0] m_exp;

    always_comb begin
        m_tick = (m_div == 16'(CLK_DIV - 1));
        m_bnd  = m_tick && (m_cnt == 8'hFF);
`ifdef PWM_SHADOW_EN
        m_dsel = m_duty;
`else
        m_dsel = duty;
`endif
        m_lvl  = (m_dsel == 8'hFF) ? 1'b1 : (m_cnt < m_dsel);
        m_exp  = '0;
        for (int i = 0; i < 16; i++) begin
            if (en_out[i]) m_exp[i] = en_pwm[i] ? m_lvl : 1'b1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_div  <= '0;
            m_cnt  <= '0;
            m_duty <= '0;
            sb.delete();
        end else begin
            sb.push_back('{out: m_exp, ps: m_bnd});
            m_div <= m_tick ? 16'd0 : m_div + 16'd1;
            if (m_tick) m_cnt <= m_cnt + 8'd1;
            if (m_bnd) m_duty <= duty;
        end
    end

    // Advance to the next falling edge and fetch the matching expectation.
    task automatic cycle();
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            have_exp = 1'b1;
        end else begin
            have_exp = 1'b0;
        end
    endtask

    task automatic test_reset();
        int n;
        int highs;
        logic seen;
        rst_n  = 1'b0;
        en_out = 16'h0001;
        en_pwm = 16'h0001;
        duty   = 8'h80;
        repeat (3) cycle();
        tests++;
        if (pwm_out !== 16'h0000) begin
            fails++;
            $display("FAIL reset_out got %h want 0000", pwm_out);
        end
        tests++;
        if (period_start !== 1'b0) begin
            fails++;
            $display("FAIL reset_ps got %b want 0", period_start);
        end
        rst_n = 1'b1;
        n = 0; highs = 0; seen = 1'b0;
        while (!seen && n < WAIT_MAX) begin
            cycle();
            n++;
            if (pwm_out[0]) highs++;
            if (have_exp) begin
                tests++;
                if ({pwm_out, period_start} !== e) begin
                    fails++;
                    $display("FAIL sb_reset t=%0t got %h/%b want %h/%b", $time, pwm_out, period_start, e.out, e.ps);
                end
            end
            if (period_start) seen = 1'b1;
        end
        tests++;
        if (n != PERIOD) begin
            fails++;
            $display("FAIL first_period got %0d cycles want %0d", n, PERIOD);
        end
        tests++;
`ifdef PWM_SHADOW_EN
        if (highs != 0) begin
            fails++;
            $display("FAIL low_until_boundary got %0d highs want 0", highs);
        end
`else
        if (highs != 512) begin
            fails++;
            $display("FAIL live_duty_first got %0d highs want 512", highs);
        end
`endif
    endtask

    task automatic test_static();
        int n;
        logic seen;
        en_out = 16'hFFFF;
        en_pwm = 16'h0000;
        cycle();
        tests++;
        if (pwm_out !== 16'hFFFF) begin
            fails++;
            $display("FAIL static_out got %h want ffff", pwm_out);
        end
        for (int k = 0; k < 2; k++) begin
            n = 0; seen = 1'b0;
            while (!seen && n < WAIT_MAX) begin
                cycle();
                n++;
                if (have_exp) begin
                    tests++;
                    if ({pwm_out, period_start} !== e) begin
                        fails++;
                        $display("FAIL sb_static t=%0t got %h/%b want %h/%b", $time, pwm_out, period_start, e.out, e.ps);
                    end
                end
                if (period_start) seen = 1'b1;
            end
            tests++;
            if (!seen) begin
                fails++;
                $display("FAIL static_ps_timeout got none want pulse");
            end
        end
        tests++;
        if (n != PERIOD) begin
            fails++;
            $display("FAIL ps_interval got %0d want %0d", n, PERIOD);
        end
    endtask

    // Waits for the next period_start, then counts channel-0 highs over one period.
    // If change_at > 0, duty is set to new_duty after that many samples.
    task automatic measure(input int change_at, input logic [7:0] new_duty, output int highs);
        int n;
        logic seen;
        n = 0; seen = 1'b0;
        while (!seen && n < WAIT_MAX) begin
            cycle();
            n++;
            if (have_exp) begin
                tests++;
                if ({pwm_out, period_start} !== e) begin
                    fails++;
                    $display("FAIL sb_wait t=%0t got %h/%b want %h/%b", $time, pwm_out, period_start, e.out, e.ps);
                end
            end
            if (period_start) seen = 1'b1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL measure_timeout got none want pulse");
        end
        highs = 0;
        for (int s = 1; s <= int'(PERIOD); s++) begin
            cycle();
            if (pwm_out[0]) highs++;
            if (have_exp) begin
                tests++;
                if ({pwm_out, period_start} !== e) begin
                    fails++;
                    $display("FAIL sb_window t=%0t got %h/%b want %h/%b", $time, pwm_out, period_start, e.out, e.ps);
                end
            end
            if (s == change_at) duty = new_duty;
        end
        tests++;
        if (period_start !== 1'b1) begin
            fails++;
            $display("FAIL window_end_ps got %b want 1", period_start);
        end
    endtask

    task automatic test_pwm_half();
        int h;
        en_out = 16'h0001;
        en_pwm = 16'h0001;
        duty   = 8'h80;
        measure(0, 8'h00, h);
        measure(0, 8'h00, h);
        tests++;
        if (h != 512) begin
            fails++;
            $display("FAIL half_duty got %0d highs want 512", h);
        end
    endtask

    task automatic test_duty_extremes();
        int h;
        duty = 8'h00;
        measure(0, 8'h00, h);
        measure(0, 8'h00, h);
        tests++;
        if (h != 0) begin
            fails++;
            $display("FAIL duty_00 got %0d highs want 0", h);
        end
        duty = 8'hFF;
        measure(0, 8'h00, h);
        measure(0, 8'h00, h);
        tests++;
        if (h != int'(PERIOD)) begin
            fails++;
            $display("FAIL duty_ff got %0d highs want %0d", h, PERIOD);
        end
    endtask

    task automatic test_duty_change();
        int h;
        duty = 8'h40;
        measure(0, 8'h00, h);
        measure(300, 8'hC0, h);
        tests++;
`ifdef PWM_SHADOW_EN
        if (h != 256) begin
            fails++;
            $display("FAIL change_cur got %0d highs want 256", h);
        end
`else
        if (h != 724) begin
            fails++;
            $display("FAIL change_cur_live got %0d highs want 724", h);
        end
`endif
        measure(0, 8'h00, h);
        tests++;
        if (h != 768) begin
            fails++;
            $display("FAIL change_next got %0d highs want 768", h);
        end
    endtask

    task automatic test_enable_gate();
        int h;
        en_out = 16'h0000;
        en_pwm = 16'h0020;
        duty   = 8'hFF;
        measure(0, 8'h00, h);
        repeat (5) cycle();
        tests++;
        if (pwm_out[5] !== 1'b0) begin
            fails++;
            $display("FAIL gate_off got %b want 0", pwm_out[5]);
        end
        en_out = 16'h0020;
        cycle();
        tests++;
        if (pwm_out[5] !== 1'b1) begin
            fails++;
            $display("FAIL gate_on got %b want 1", pwm_out[5]);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic seen;
        en_out = 16'hFFFF;
        en_pwm = 16'h0000;
        repeat (300) cycle();
        tests++;
        if (pwm_out !== 16'hFFFF) begin
            fails++;
            $display("FAIL pre_reset got %h want ffff", pwm_out);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (pwm_out !== 16'h0000 || period_start !== 1'b0) begin
            fails++;
            $display("FAIL async_reset got %h/%b want 0000/0", pwm_out, period_start);
        end
        repeat (2) cycle();
        rst_n = 1'b1;
        n = 0; seen = 1'b0;
        while (!seen && n < WAIT_MAX) begin
            cycle();
            n++;
            if (have_exp) begin
                tests++;
                if ({pwm_out, period_start} !== e) begin
                    fails++;
                    $display("FAIL sb_rmid t=%0t got %h/%b want %h/%b", $time, pwm_out, period_start, e.out, e.ps);
                end
            end
            if (period_start) seen = 1'b1;
        end
        tests++;
        if (n != PERIOD) begin
            fails++;
            $display("FAIL reset_mid_period got %0d cycles want %0d", n, PERIOD);
        end
    endtask

    initial begin
        test_reset();
        test_static();
        test_pwm_half();
        test_duty_extremes();
        test_duty_change();
        test_enable_gate();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
